uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART receiver. It generates the 16x oversampling clock enable from a programmable divisor. It detects each completed byte from the receiver's sticky `ready` flag, pushes the byte into a small show-ahead FIFO, and clears the receiver for the next frame. Host logic drains the FIFO through a valid/ready handshake and sees overrun and interrupt status.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_ctrl_if.sv | 26 ++
 rtl/uart_rx_fifo.sv | 61 ++++++
 rtl/uart_rx_ctrl.sv | 102 ++++++++++
 tb/tb_uart_rx_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side controller.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CAPTURE,
        CLEAR
    } rx_ctrl_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Host-side read port of the receive controller: FIFO drain handshake plus status.
interface uart_rx_ctrl_if #(
    parameter int DEPTH = 4
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   rd_valid;
    logic [UART_DATA_W-1:0] rd_data;
    logic                   rd_ready;
    logic [CNT_W-1:0]       fifo_count;
    logic                   overrun;
    logic                   overrun_clr;
    logic                   irq;

    modport slave (
        output rd_valid, rd_data, fifo_count, overrun, irq,
        input  rd_ready, overrun_clr
    );

    modport master (
        input  rd_valid, rd_data, fifo_count, overrun, irq,
        output rd_ready, overrun_clr
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Small show-ahead FIFO: head is always presented on the output, pop advances it.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             rd_valid,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full
);
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             pop_ok;
    logic             push_ok;

    assign rd_valid = (count_reg != '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign count    = count_reg;
    assign head     = mem_reg[rd_ptr_reg];

    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    assign pop_ok  = pop & rd_valid;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick generator, byte capture FSM,
// receive FIFO and host-visible overrun/interrupt status.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [DIV_W-1:0]       baud_div,
    output logic                   rx_clk_en,
    input  logic                   rx_ready,
    input  logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_clr,
    uart_rx_ctrl_if.slave          host
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    rx_ctrl_state_t         state_reg;
    rx_ctrl_state_t         state_next;
    logic [DIV_W-1:0]       tick_cnt_reg;
    logic                   rx_clk_en_reg;
    logic                   overrun_reg;

    logic                   fifo_push;
    logic                   fifo_valid;
    logic                   fifo_full;
    logic [UART_DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]       fifo_count;
    logic                   discard;

    // ">=" so that shrinking baud_div below the running count wraps immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_reg  <= '0;
            rx_clk_en_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
            tick_cnt_reg  <= '0;
            rx_clk_en_reg <= 1'b0;
        end else if (tick_cnt_reg >= baud_div) begin
            tick_cnt_reg  <= '0;
            rx_clk_en_reg <= 1'b1;
        end else begin
            tick_cnt_reg  <= tick_cnt_reg + DIV_W'(1);
            rx_clk_en_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (enable) state_next = RUN;
            RUN: begin
                if (!enable)       state_next = IDLE;
                else if (rx_ready) state_next = CAPTURE;
            end
            CAPTURE: state_next = CLEAR;
            // Stay here until the receiver has actually dropped ready.
            CLEAR:   if (!rx_ready) state_next = enable ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rx_clk_en = rx_clk_en_reg;
    assign rx_clr    = (state_reg == CAPTURE) || (state_reg == CLEAR);
    assign fifo_push = (state_reg == CAPTURE);
    assign discard   = fifo_push & fifo_full & ~(host.rd_ready & fifo_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)             overrun_reg <= 1'b0;
        else if (discard)         overrun_reg <= 1'b1;
        else if (host.overrun_clr) overrun_reg <= 1'b0;
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (rx_data),
        .pop       (host.rd_ready),
        .rd_valid  (fifo_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    assign host.rd_valid   = fifo_valid;
    assign host.rd_data    = fifo_head;
    assign host.fifo_count = fifo_count;
    assign host.overrun    = overrun_reg;
    assign host.irq        = fifo_valid | overrun_reg;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a queue-based model of FIFO and overrun.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] baud_div = '0;
    logic        rx_clk_en;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_clr;

    uart_rx_ctrl_if #(.DEPTH(DEPTH)) host();

    uart_rx_ctrl #(.DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .baud_div  (baud_div),
        .rx_clk_en (rx_clk_en),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_clr    (rx_clr),
        .host      (host)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] model_q[$];
    bit         model_ovr = 1'b0;

    // Receiver stand-in: raise ready with a byte, wait for CAPTURE, optionally pop
    // and/or clear overrun in that cycle, drop ready at the clearing edge.
    task automatic send_byte(input logic [7:0] d, input bit pop_cap, input bit clr_cap,
                             output bit timed_out);
        bit was_full;
        bit popped;
        timed_out = 1'b1;
        @(negedge clk);
        rx_data  = d;
        rx_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rx_clr) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (timed_out) begin
            rx_ready = 1'b0;
            return;
        end
        host.rd_ready    = pop_cap;
        host.overrun_clr = clr_cap;
        was_full = (model_q.size() == DEPTH);
        popped   = pop_cap && (model_q.size() > 0);
        if (popped) void'(model_q.pop_front());
        if (!was_full || popped) begin
            model_q.push_back(d);
            if (clr_cap) model_ovr = 1'b0;
        end else begin
            model_ovr = 1'b1;
        end
        @(posedge clk); #1;
        rx_ready         = 1'b0;
        host.rd_ready    = 1'b0;
        host.overrun_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pop_one(output logic [7:0] got);
        @(negedge clk);
        got = host.rd_data;
        host.rd_ready = 1'b1;
        @(posedge clk); #1;
        host.rd_ready = 1'b0;
    endtask

    task automatic clear_overrun();
        @(negedge clk);
        host.overrun_clr = 1'b1;
        @(posedge clk); #1;
        host.overrun_clr = 1'b0;
        model_ovr = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (host.rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %0b expected 0", host.rd_valid); end
        vectors++; if (host.fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", host.fifo_count); end
        vectors++; if (host.rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data: got %02h expected 00", host.rd_data); end
        vectors++; if (host.overrun !== 1'b0 || host.irq !== 1'b0) begin miscompares++; $display("FAIL reset_status: got ovr %0b irq %0b expected 0 0", host.overrun, host.irq); end
        vectors++; if (rx_clr !== 1'b0 || rx_clk_en !== 1'b0) begin miscompares++; $display("FAIL reset_rx: got clr %0b tick %0b expected 0 0", rx_clr, rx_clk_en); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_tick(input int div);
        int pulses;
        int first;
        @(negedge clk);
        enable   = 1'b0;
        baud_div = 16'(div);
        repeat (2) @(negedge clk);
        pulses = 0;
        repeat (20) begin @(negedge clk); if (rx_clk_en) pulses++; end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL tick_idle(div=%0d): got %0d pulses expected 0", div, pulses); end
        enable = 1'b1;
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rx_clk_en) begin first = i; break; end
        end
        vectors++; if (first !== div + 2) begin miscompares++; $display("FAIL tick_first(div=%0d): got %0d cycles expected %0d", div, first, div + 2); end
        pulses = 0;
        repeat (8 * (div + 1)) begin @(negedge clk); if (rx_clk_en) pulses++; end
        vectors++; if (pulses !== 8) begin miscompares++; $display("FAIL tick_rate(div=%0d): got %0d pulses expected 8", div, pulses); end
        $display("tick: div %0d first %0d pulses %0d", div, first, pulses);
    endtask

    task automatic test_single();
        logic [7:0] got;
        logic [7:0] exp;
        @(negedge clk);
        rx_data  = 8'hA5;
        rx_ready = 1'b1;
        @(negedge clk);
        vectors++; if (rx_clr !== 1'b1 || host.rd_valid !== 1'b0) begin miscompares++; $display("FAIL single_capture: got clr %0b valid %0b expected 1 0", rx_clr, host.rd_valid); end
        @(posedge clk); #1;
        rx_ready = 1'b0;
        model_q.push_back(8'hA5);
        @(negedge clk);
        vectors++; if (host.rd_valid !== 1'b1 || host.rd_data !== 8'hA5 || host.fifo_count !== 3'd1) begin
            miscompares++; $display("FAIL single_push: got valid %0b data %02h count %0d expected 1 a5 1", host.rd_valid, host.rd_data, host.fifo_count); end
        vectors++; if (rx_clr !== 1'b1) begin miscompares++; $display("FAIL single_clear: got clr %0b expected 1", rx_clr); end
        @(negedge clk);
        vectors++; if (rx_clr !== 1'b0) begin miscompares++; $display("FAIL single_resume: got clr %0b expected 0", rx_clr); end
        pop_one(got);
        exp = model_q.pop_front();
        @(negedge clk);
        vectors++; if (got !== exp || host.rd_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop: got %02h valid %0b expected %02h 0", got, host.rd_valid, exp); end
        $display("single: byte %02h read %02h", exp, got);
    endtask

    task automatic test_overrun_fill();
        bit to;
        logic [7:0] got;
        logic [7:0] exp;
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), 1'b0, 1'b0, to);
            vectors++; if (to) begin miscompares++; $display("FAIL fill_timeout: byte %0d got no capture expected capture", i); end
        end
        vectors++; if (host.fifo_count !== 3'd4 || host.overrun !== 1'b0) begin miscompares++; $display("FAIL fill_count: got count %0d ovr %0b expected 4 0", host.fifo_count, host.overrun); end
        send_byte(8'hFF, 1'b0, 1'b0, to);
        vectors++; if (host.fifo_count !== 3'(model_q.size()) || host.overrun !== model_ovr || host.irq !== 1'b1) begin
            miscompares++; $display("FAIL fill_overrun: got count %0d ovr %0b irq %0b expected %0d %0b 1", host.fifo_count, host.overrun, host.irq, model_q.size(), model_ovr); end
        while (model_q.size() > 0) begin
            pop_one(got);
            exp = model_q.pop_front();
            vectors++; if (got !== exp) begin miscompares++; $display("FAIL fill_read: got %02h expected %02h", got, exp); end
            $display("fill: read %02h expected %02h", got, exp);
        end
        @(negedge clk);
        vectors++; if (host.rd_valid !== 1'b0 || host.irq !== 1'b1) begin miscompares++; $display("FAIL fill_drained: got valid %0b irq %0b expected 0 1", host.rd_valid, host.irq); end
        clear_overrun();
        @(negedge clk);
        vectors++; if (host.overrun !== 1'b0 || host.irq !== 1'b0) begin miscompares++; $display("FAIL fill_clear: got ovr %0b irq %0b expected 0 0", host.overrun, host.irq); end
    endtask

    task automatic test_full_pop();
        bit to;
        logic [7:0] got;
        logic [7:0] exp;
        logic [7:0] nb;
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'b0, 1'b0, to);
        nb = 8'($urandom);
        send_byte(nb, 1'b1, 1'b0, to);
        vectors++; if (to || host.overrun !== 1'b0 || host.fifo_count !== 3'd4) begin
            miscompares++; $display("FAIL full_pop: got timeout %0b ovr %0b count %0d expected 0 0 4", to, host.overrun, host.fifo_count); end
        while (model_q.size() > 0) begin
            pop_one(got);
            exp = model_q.pop_front();
            vectors++; if (got !== exp) begin miscompares++; $display("FAIL full_pop_read: got %02h expected %02h", got, exp); end
        end
        vectors++; if (got !== nb) begin miscompares++; $display("FAIL full_pop_last: got %02h expected %02h", got, nb); end
        $display("full_pop: new byte %02h last read %02h", nb, got);
    endtask

    task automatic test_ovr_same_cycle();
        bit to;
        logic [7:0] got;
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'b0, 1'b0, to);
        send_byte(8'h5A, 1'b0, 1'b1, to);
        vectors++; if (host.overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set_wins: got %0b expected 1", host.overrun); end
        clear_overrun();
        @(negedge clk);
        vectors++; if (host.overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clear: got %0b expected 0", host.overrun); end
        while (model_q.size() > 0) begin pop_one(got); void'(model_q.pop_front()); end
        $display("ovr_same_cycle: done");
    endtask

    task automatic test_random();
        bit to;
        bit pc;
        bit cc;
        logic [7:0] d;
        logic [7:0] got;
        logic [7:0] exp;
        for (int t = 0; t < 24; t++) begin
            d  = 8'($urandom);
            pc = 1'($urandom_range(0, 1));
            cc = ($urandom_range(0, 3) == 0);
            send_byte(d, pc, cc, to);
            vectors++; if (to) begin miscompares++; $display("FAIL rand_timeout: txn %0d got no capture expected capture", t); end
            if ($urandom_range(0, 2) == 0 && model_q.size() > 0) begin
                pop_one(got);
                exp = model_q.pop_front();
                vectors++; if (got !== exp) begin miscompares++; $display("FAIL rand_pop: got %02h expected %02h", got, exp); end
                @(negedge clk);
            end
            vectors++; if (host.fifo_count !== 3'(model_q.size()) || host.rd_valid !== (model_q.size() > 0) ||
                           host.overrun !== model_ovr || host.irq !== ((model_q.size() > 0) || model_ovr)) begin
                miscompares++; $display("FAIL rand_status: txn %0d got count %0d valid %0b ovr %0b irq %0b expected count %0d ovr %0b",
                                        t, host.fifo_count, host.rd_valid, host.overrun, host.irq, model_q.size(), model_ovr); end
            if (model_q.size() > 0) begin
                vectors++; if (host.rd_data !== model_q[0]) begin miscompares++; $display("FAIL rand_head: got %02h expected %02h", host.rd_data, model_q[0]); end
            end
            $display("txn %0d: byte %02h pop %0b clr %0b count %0d ovr %0b", t, d, pc, cc, model_q.size(), model_ovr);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int first;
        int pulses;
        if (model_ovr) clear_overrun();
        while (model_q.size() > 0) begin logic [7:0] g; pop_one(g); void'(model_q.pop_front()); end
        send_byte(8'h11, 1'b0, 1'b0, to);
        @(negedge clk);
        rx_data  = 8'h22;
        rx_ready = 1'b1;
        @(negedge clk);
        vectors++; if (rx_clr !== 1'b1) begin miscompares++; $display("FAIL mid_capture: got clr %0b expected 1", rx_clr); end
        @(posedge clk); #1;
        rx_ready = 1'b0;
        #1;
        vectors++; if (host.fifo_count !== 3'd2 || rx_clr !== 1'b1) begin miscompares++; $display("FAIL mid_queued: got count %0d clr %0b expected 2 1", host.fifo_count, rx_clr); end
        reset_n = 1'b0;
        #1;
        model_q.delete();
        model_ovr = 1'b0;
        vectors++; if (host.rd_valid !== 1'b0 || host.fifo_count !== 3'd0 || host.rd_data !== 8'h00 || host.irq !== 1'b0 || host.overrun !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset_fifo: got valid %0b count %0d data %02h irq %0b ovr %0b expected 0 0 00 0 0",
                                    host.rd_valid, host.fifo_count, host.rd_data, host.irq, host.overrun); end
        vectors++; if (rx_clr !== 1'b0 || rx_clk_en !== 1'b0) begin miscompares++; $display("FAIL mid_reset_rx: got clr %0b tick %0b expected 0 0", rx_clr, rx_clk_en); end
        @(negedge clk);
        enable   = 1'b0;
        baud_div = 16'd0;
        reset_n  = 1'b1;
        pulses = 0;
        repeat (5) begin @(negedge clk); if (rx_clk_en || rx_clr) pulses++; end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL mid_idle: got %0d active cycles expected 0", pulses); end
        enable = 1'b1;
        first = 0;
        for (int i = 1; i <= 10; i++) begin @(negedge clk); if (rx_clk_en) begin first = i; break; end end
        vectors++; if (first !== 2) begin miscompares++; $display("FAIL mid_restart: got %0d cycles expected 2", first); end
        $display("reset_mid: restart after %0d cycles", first);
    endtask

    initial begin
        host.rd_ready    = 1'b0;
        host.overrun_clr = 1'b0;
        test_reset();
        test_tick(3);
        test_tick($urandom_range(0, 6));
        test_tick($urandom_range(1, 9));
        baud_div = 16'd3;
        test_single();
        test_overrun_fill();
        test_full_pop();
        test_ovr_same_cycle();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
